// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, keys fetched by index.
// Define AES_INV_OUT_REG_EN to add a registered output stage (one extra cycle).
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  fsm_t         fsm_q, fsm_n;
  logic [3:0]   r_q, r_n;
  logic [127:0] st_q, st_n;
  logic [127:0] sb, ak, mc;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse affine, then x^254 == x^-1 in GF(2^8) (0 maps to 0)
  function automatic logic [7:0] isbox(input logic [7:0] y);
    logic [7:0] a, p, q;
    a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]}
      ^ {y[1:0], y[7:2]} ^ 8'h05;
    p = a;
    q = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      q = gmul(q, p);
    end
    return q;
  endfunction

  function automatic logic [31:0] imix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {
      gmul(8'h0e, a0) ^ gmul(8'h0b, a1)
        ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
      gmul(8'h09, a0) ^ gmul(8'h0e, a1)
        ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
      gmul(8'h0d, a0) ^ gmul(8'h09, a1)
        ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
      gmul(8'h0b, a0) ^ gmul(8'h0d, a1)
        ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)
    };
  endfunction

  // byte k = 4*col + row sits at [127-8k -: 8]
  always_comb begin
    sb = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        sb[127-8*(4*c+rw) -: 8] =
          isbox(st_q[127-8*(4*((c+4-rw)%4)+rw) -: 8]);
      end
    end
    ak = sb ^ rk_data;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = imix(ak[127-32*c -: 32]);
    end
  end

`ifdef AES_INV_OUT_REG_EN
  logic         ov_q, ov_n;
  logic [127:0] od_q, od_n;
`endif

  always_comb begin
    fsm_n    = fsm_q;
    r_n      = r_q;
    st_n     = st_q;
    in_ready = 1'b0;
    rk_idx   = 4'd0;
`ifdef AES_INV_OUT_REG_EN
    ov_n     = ov_q;
    od_n     = od_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'(NR);
        if (in_valid) begin
          st_n  = in_data ^ rk_data;
          r_n   = 4'(NR - 1);
          fsm_n = ROUND;
        end
      end
      ROUND: begin
        rk_idx = r_q;
        if (r_q != 4'd0) begin
          st_n = mc;
          r_n  = r_q - 4'd1;
        end else begin
          st_n  = ak;
          fsm_n = DONE;
        end
      end
      DONE: begin
`ifdef AES_INV_OUT_REG_EN
        if (!ov_q) begin
          ov_n = 1'b1;
          od_n = st_q;
        end else if (out_ready) begin
          ov_n  = 1'b0;
          fsm_n = IDLE;
        end
`else
        if (out_ready) fsm_n = IDLE;
`endif
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      r_q   <= '0;
      st_q  <= '0;
`ifdef AES_INV_OUT_REG_EN
      ov_q  <= 1'b0;
      od_q  <= '0;
`endif
    end else begin
      fsm_q <= fsm_n;
      r_q   <= r_n;
      st_q  <= st_n;
`ifdef AES_INV_OUT_REG_EN
      ov_q  <= ov_n;
      od_q  <= od_n;
`endif
    end
  end

`ifdef AES_INV_OUT_REG_EN
  assign out_valid = ov_q;
  assign out_data  = od_q;
`else
  assign out_valid = (fsm_q == DONE);
  assign out_data  = st_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128 and AES-256 instances checked
// against a forward-cipher reference model and FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

`ifdef AES_INV_OUT_REG_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         v10, v14, ir10, ir14, ov10, ov14;
  logic [3:0]   ri10, ri14;
  logic [127:0] rd10, rd14, od10, od14;
  logic         o_ir, o_ov;
  logic [3:0]   o_ri;
  logic [127:0] o_od;

  logic [127:0] rkt[2][16];
  logic [7:0]   sbox[256];
  int           checks = 0;
  int           errors = 0;

  assign v10  = in_valid & ~sel;
  assign v14  = in_valid & sel;
  assign rd10 = rkt[0][ri10];
  assign rd14 = rkt[1][ri14];
  assign o_ir = sel ? ir14 : ir10;
  assign o_ov = sel ? ov14 : ov10;
  assign o_ri = sel ? ri14 : ri10;
  assign o_od = sel ? od14 : od10;

  aes_inv_cipher_iter #(.NR(10)) u_aes128 (
    .clk(clk), .rst(rst),
    .in_valid(v10), .in_ready(ir10), .in_data(in_data),
    .rk_idx(ri10), .rk_data(rd10),
    .out_valid(ov10), .out_ready(out_ready), .out_data(od10)
  );

  aes_inv_cipher_iter #(.NR(14)) u_aes256 (
    .clk(clk), .rst(rst),
    .in_valid(v14), .in_ready(ir14), .in_data(in_data),
    .rk_idx(ri14), .rk_data(rd14),
    .out_valid(ov14), .out_ready(out_ready), .out_data(od14)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int nrc();
    return sel ? 14 : 10;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
              ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input int k, input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = k ? 8 : 4;
    nr = k ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) rkt[k][j] = '0;
    for (int j = 0; j <= nr; j++)
      rkt[k][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // forward cipher: the DUT must invert this
  function automatic logic [127:0] enc(input logic [127:0] pt, input int k);
    logic [127:0] x;
    logic [7:0]   a[16], t[16];
    int nr;
    nr = k ? 14 : 10;
    x = pt ^ rkt[k][0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) a[i] = sbox[x[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = a[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          a[4*c+r] = (rd == nr) ? t[4*c+r] :
            gm(8'h02, t[4*c+r]) ^ gm(8'h03, t[4*c+(r+1)%4])
            ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) x[127-8*i -: 8] = a[i];
      x = x ^ rkt[k][rd];
    end
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setsel(input logic s);
    sel = s;
    #1;
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input string nm);
    int n, g, lat;
    bit rkok;
    n = nrc();
    in_data = ct;
    in_valid = 1'b1;
    out_ready = 1'b1;
    g = 0;
    while (o_ir !== 1'b1 && g < 40) begin
      step();
      g++;
    end
    checks++;
    if (o_ir !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b want 1", nm, o_ir);
    end
    checks++;
    if (o_ri !== 4'(n)) begin
      errors++;
      $display("FAIL %s rk_first: got %0d want %0d", nm, o_ri, n);
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    rkok = 1'b1;
    while (o_ov !== 1'b1 && lat < 40) begin
      if (lat < n && o_ri !== 4'(n - 1 - lat)) rkok = 1'b0;
      step();
      lat++;
    end
    checks++;
    if (!rkok) begin
      errors++;
      $display("FAIL %s rk_seq: got gaps want %0d..0", nm, n);
    end
    checks++;
    if (lat != n + XTRA) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, n + XTRA);
    end
    checks++;
    if (o_od !== pt) begin
      errors++;
      $display("FAIL %s data: got %h want %h", nm, o_od, pt);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    in_valid = 1'b1;
    in_data = rnd();
    out_ready = 1'b1;
    step();
    step();
    checks += 8;
    if (ir10 !== 1'b1) begin errors++; $display("FAIL rst ir10: got %b want 1", ir10); end
    if (ov10 !== 1'b0) begin errors++; $display("FAIL rst ov10: got %b want 0", ov10); end
    if (od10 !== '0) begin errors++; $display("FAIL rst od10: got %h want 0", od10); end
    if (ri10 !== 4'd10) begin errors++; $display("FAIL rst ri10: got %0d want 10", ri10); end
    if (ir14 !== 1'b1) begin errors++; $display("FAIL rst ir14: got %b want 1", ir14); end
    if (ov14 !== 1'b0) begin errors++; $display("FAIL rst ov14: got %b want 0", ov14); end
    if (od14 !== '0) begin errors++; $display("FAIL rst od14: got %h want 0", od14); end
    if (ri14 !== 4'd14) begin errors++; $display("FAIL rst ri14: got %0d want 14", ri14); end
    rst = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_fips();
    setsel(1'b0);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, "fips128");
    setsel(1'b1);
    run_block(128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, "fips256");
  endtask

  task automatic test_random();
    logic [127:0] pt;
    for (int k = 0; k < 2; k++) begin
      setsel(k[0]);
      set_key(k, {rnd(), rnd()});
      for (int i = 0; i < 5; i++) begin
        pt = rnd();
        run_block(enc(pt, k), pt, k ? "rand256" : "rand128");
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] pt;
    int g;
    setsel(1'b1);
    pt = rnd();
    in_data = enc(pt, 1);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    g = 0;
    while (o_ov !== 1'b1 && g < 40) begin
      step();
      g++;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data = rnd();
      checks += 3;
      if (o_ov !== 1'b1) begin errors++; $display("FAIL stall ov[%0d]: got %b want 1", k, o_ov); end
      if (o_od !== pt) begin errors++; $display("FAIL stall od[%0d]: got %h want %h", k, o_od, pt); end
      if (o_ir !== 1'b0) begin errors++; $display("FAIL stall ir[%0d]: got %b want 0", k, o_ir); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks += 3;
    if (o_ir !== 1'b1) begin errors++; $display("FAIL release ir: got %b want 1", o_ir); end
    if (o_ov !== 1'b0) begin errors++; $display("FAIL release ov: got %b want 0", o_ov); end
    if (o_od !== pt) begin errors++; $display("FAIL release hold: got %h want %h", o_od, pt); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    bit seen;
    setsel(1'b0);
    pt = rnd();
    in_data = enc(pt, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 3;
    if (o_ir !== 1'b1) begin errors++; $display("FAIL midrst ir: got %b want 1", o_ir); end
    if (o_ov !== 1'b0) begin errors++; $display("FAIL midrst ov: got %b want 0", o_ov); end
    if (o_od !== '0) begin errors++; $display("FAIL midrst od: got %h want 0", o_od); end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (o_ov === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst ghost: got out_valid=1 want 0"); end
    pt = rnd();
    run_block(enc(pt, 0), pt, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts[64], cts[64];
    logic [127:0] q[$];
    logic [127:0] exp;
    int acc[$];
    int per, g;
    setsel(1'b0);
    per = 12 + XTRA;
    for (int i = 0; i < 64; i++) begin
      pts[i] = rnd();
      cts[i] = enc(pts[i], 0);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_data = cts[cyc];
      in_valid = 1'b1;
      #1;
      if (o_ir === 1'b1) begin
        q.push_back(pts[cyc]);
        acc.push_back(cyc);
      end
      if (o_ov === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b spurious: got %h want none", o_od);
        end else begin
          exp = q.pop_front();
          if (o_od !== exp) begin
            errors++;
            $display("FAIL b2b data: got %h want %h", o_od, exp);
          end
        end
      end
      step();
    end
    in_valid = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 40) begin
      if (o_ov === 1'b1) begin
        exp = q.pop_front();
        checks++;
        if (o_od !== exp) begin
          errors++;
          $display("FAIL b2b drain: got %h want %h", o_od, exp);
        end
      end
      step();
      g++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b lost: got %0d pending want 0", q.size());
    end
    checks++;
    if (acc.size() != 5) begin
      errors++;
      $display("FAIL b2b accepts: got %0d want 5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != per) begin
        errors++;
        $display("FAIL b2b period: got %0d want %0d", acc[i] - acc[i-1], per);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    build_sbox();
    set_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    set_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    test_reset();
    test_fips();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
